hawk_decomp_pgwr: RTL and testbench

HAWK_DECOMP_PGWR -- requirements
Module: hawk_decomp_pgwr

---
 rtl/hacd_pkg.sv | 17 +
 rtl/hawk_decomp_pgwr_if.sv | 40 ++++
 rtl/hawk_decomp_pgwr.sv | 108 ++++++++++
 tb/tb_hawk_decomp_pgwr.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hacd_pkg.sv
// Shared HACD constants and the page-writer FSM state encoding.
package hacd_pkg;

    localparam int PAGE_LINES = 64;
    localparam int LINE_SHIFT = 6;
    localparam int PAGE_SHIFT = 12;

    typedef logic [2:0] pgwr_state_t;

    localparam pgwr_state_t PGWR_IDLE  = 3'd0;
    localparam pgwr_state_t PGWR_LOAD  = 3'd1;
    localparam pgwr_state_t PGWR_ISSUE = 3'd2;
    localparam pgwr_state_t PGWR_RESP  = 3'd3;
    localparam pgwr_state_t PGWR_DONE  = 3'd4;
    localparam pgwr_state_t PGWR_ERROR = 3'd5;

endpackage

// File: rtl/hawk_decomp_pgwr_if.sv
// Page-writer bus bundle: manager control, cacheline stream and AXI write channels.
interface hawk_decomp_pgwr_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 512
);
    logic                  dcmp_wr_start;
    logic [ADDR_W-1:0]     dcmp_wr_pgaddr;
    logic                  line_valid;
    logic [DATA_W-1:0]     line_data;
    logic                  line_ready;
    logic                  awvalid;
    logic [ADDR_W-1:0]     awaddr;
    logic [7:0]            awlen;
    logic                  awready;
    logic                  wvalid;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  wlast;
    logic                  wready;
    logic                  bvalid;
    logic [1:0]            bresp;
    logic                  bready;
    logic                  busy;
    logic                  dcmp_wr_done;
    logic                  dcmp_wr_error;

    modport master (
        input  dcmp_wr_start, dcmp_wr_pgaddr, line_valid, line_data,
               awready, wready, bvalid, bresp,
        output line_ready, awvalid, awaddr, awlen, wvalid, wdata, wstrb, wlast,
               bready, busy, dcmp_wr_done, dcmp_wr_error
    );

    modport slave (
        output dcmp_wr_start, dcmp_wr_pgaddr, line_valid, line_data,
               awready, wready, bvalid, bresp,
        input  line_ready, awvalid, awaddr, awlen, wvalid, wdata, wstrb, wlast,
               bready, busy, dcmp_wr_done, dcmp_wr_error
    );
endinterface

// File: rtl/hawk_decomp_pgwr.sv
// Writes one decompressed 4KB page to memory as single-beat AXI writes,
// one outstanding write at a time.
module hawk_decomp_pgwr
    import hacd_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 512,
    parameter int LINES  = PAGE_LINES
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    hawk_decomp_pgwr_if.master   bus
);

    localparam int CNT_W = $clog2(LINES) + 1;
    localparam logic [ADDR_W-1:0] PAGE_OFF_MASK = ADDR_W'((1 << PAGE_SHIFT) - 1);

    pgwr_state_t         state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   buf_q, buf_d;
    logic                aw_pend_q, aw_pend_d;
    logic                w_pend_q, w_pend_d;
    logic                err_q, err_d;

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        aw_pend_d = aw_pend_q;
        w_pend_d  = w_pend_q;
        err_d     = err_q;
        unique case (state_q)
            PGWR_IDLE: begin
                cnt_d = '0;
                if (bus.dcmp_wr_start) begin
                    base_d  = bus.dcmp_wr_pgaddr & ~PAGE_OFF_MASK;
                    state_d = PGWR_LOAD;
                end
            end
            PGWR_LOAD: begin
                if (bus.line_valid) begin
                    buf_d     = bus.line_data;
                    aw_pend_d = 1'b1;
                    w_pend_d  = 1'b1;
                    state_d   = PGWR_ISSUE;
                end
            end
            PGWR_ISSUE: begin
                // AW and W retire independently; leave only once both have gone.
                if (aw_pend_q && bus.awready) aw_pend_d = 1'b0;
                if (w_pend_q && bus.wready)   w_pend_d  = 1'b0;
                if (!aw_pend_d && !w_pend_d)  state_d   = PGWR_RESP;
            end
            PGWR_RESP: begin
                if (bus.bvalid) begin
                    if (bus.bresp != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = PGWR_ERROR;
                    end else if (cnt_q == CNT_W'(LINES - 1)) begin
                        state_d = PGWR_DONE;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = PGWR_LOAD;
                    end
                end
            end
            PGWR_DONE:  state_d = PGWR_IDLE;
            PGWR_ERROR: state_d = PGWR_ERROR;
            default:    state_d = PGWR_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= PGWR_IDLE;
            base_q    <= '0;
            cnt_q     <= '0;
            buf_q     <= '0;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            cnt_q     <= cnt_d;
            buf_q     <= buf_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
            err_q     <= err_d;
        end
    end

    assign bus.line_ready    = (state_q == PGWR_LOAD);
    assign bus.awvalid       = (state_q == PGWR_ISSUE) && aw_pend_q;
    assign bus.awaddr        = base_q + (ADDR_W'(cnt_q) << LINE_SHIFT);
    assign bus.awlen         = '0;
    assign bus.wvalid        = (state_q == PGWR_ISSUE) && w_pend_q;
    assign bus.wdata         = buf_q;
    assign bus.wstrb         = '1;
    assign bus.wlast         = bus.wvalid;
    assign bus.bready        = (state_q == PGWR_RESP);
    assign bus.busy          = (state_q != PGWR_IDLE);
    assign bus.dcmp_wr_done  = (state_q == PGWR_DONE);
    assign bus.dcmp_wr_error = err_q;

endmodule

// File: tb/tb_hawk_decomp_pgwr.sv
// Bench for hawk_decomp_pgwr: table of page scenarios against a page-level
// model of expected writes, plus stall/ignored-start and mid-page reset sequences.
module tb_hawk_decomp_pgwr;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 512;
    localparam int LINES  = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hawk_decomp_pgwr_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u ();

    hawk_decomp_pgwr #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINES(LINES)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (u)
    );

    typedef struct {
        logic [63:0] pgaddr;
        int          awm;
        int          wm;
        int          bm;
        int          el;
        int          exp_writes;
        bit          exp_done;
        bit          exp_err;
    } vec_t;

    vec_t vecs[6];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [ADDR_W-1:0] aw_q[$];
    logic [DATA_W-1:0] w_q[$];
    logic [DATA_W-1:0] src[LINES];
    int  b_cnt = 0, done_cnt = 0, stab_err = 0, fmt_err = 0, overlap_err = 0;
    int  first_aw_cyc = -1, start_cyc = 0;
    int  src_idx = 0, stall_at = -1, stall_left = 0;
    bit  src_on = 1'b0;
    int  aw_mode = 0, w_mode = 0, b_mode = 0, err_line = -1;
    int  aw_wt = 0, aw_tgt = 0, w_wt = 0, w_tgt = 0;
    bit  aw_hold = 1'b0, w_hold = 1'b0;
    logic [ADDR_W-1:0] aw_hold_addr;
    logic [DATA_W-1:0] w_hold_data;

    always @(posedge clk) cyc++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // AXI slave: programmable ready delays (negative mode = random 0..3 per beat)
    always begin
        tick();
        if (u.awvalid) begin
            if (aw_wt >= aw_tgt) u.awready = 1'b1;
            else begin u.awready = 1'b0; aw_wt++; end
        end else begin
            u.awready = 1'b0;
            aw_wt     = 0;
            aw_tgt    = (aw_mode < 0) ? int'($urandom_range(0, 3)) : aw_mode;
        end
        if (u.wvalid) begin
            if (w_wt >= w_tgt) u.wready = 1'b1;
            else begin u.wready = 1'b0; w_wt++; end
        end else begin
            u.wready = 1'b0;
            w_wt     = 0;
            w_tgt    = (w_mode < 0) ? int'($urandom_range(0, 3)) : w_mode;
        end
        if (b_mode == 0) u.bvalid = 1'b1;
        else             u.bvalid = u.bready && ($urandom_range(0, 1) == 1);
        u.bresp = (b_cnt == err_line) ? 2'b10 : 2'b00;
    end

    // Cacheline source: presents lines in order, optional 10-cycle stall
    always begin
        tick();
        if (src_on && src_idx < LINES) begin
            if (src_idx == stall_at && stall_left > 0) begin
                stall_left--;
                u.line_valid = 1'b0;
            end else begin
                u.line_valid = 1'b1;
            end
            u.line_data = src[src_idx];
        end else begin
            u.line_valid = 1'b0;
        end
    end

    // Monitor: values at negedge are what the next rising edge will see
    always @(negedge clk) begin
        if (u.line_valid && u.line_ready) src_idx++;
        if (u.awvalid && u.awready) aw_q.push_back(u.awaddr);
        if (u.wvalid && u.wready) w_q.push_back(u.wdata);
        if (u.bvalid && u.bready) b_cnt++;
        if (u.dcmp_wr_done) done_cnt++;
        if (u.awvalid && first_aw_cyc < 0) first_aw_cyc = cyc;
        if (aw_hold && !(u.awvalid && u.awaddr == aw_hold_addr)) stab_err++;
        if (w_hold && !(u.wvalid && u.wdata == w_hold_data)) stab_err++;
        aw_hold      = u.awvalid && !u.awready && !rst;
        aw_hold_addr = u.awaddr;
        w_hold       = u.wvalid && !u.wready && !rst;
        w_hold_data  = u.wdata;
        if (u.awvalid && u.awlen != 8'd0) fmt_err++;
        if (u.wvalid && u.wstrb != {(DATA_W/8){1'b1}}) fmt_err++;
        if (u.wlast != u.wvalid) fmt_err++;
        if (u.line_ready && (u.awvalid || u.wvalid || u.bready)) overlap_err++;
        if (u.bready && (u.awvalid || u.wvalid)) overlap_err++;
    end

    task automatic fill_src();
        for (int i = 0; i < LINES; i++)
            for (int j = 0; j < DATA_W / 32; j++)
                src[i][j*32 +: 32] = $urandom();
    endtask

    task automatic clear_mon();
        aw_q.delete();
        w_q.delete();
        b_cnt = 0; done_cnt = 0; stab_err = 0; fmt_err = 0; overlap_err = 0;
        first_aw_cyc = -1;
        src_idx = 0;
    endtask

    function automatic logic [6:0] outs();
        return {u.awvalid, u.wvalid, u.bready, u.line_ready, u.busy,
                u.dcmp_wr_done, u.dcmp_wr_error};
    endfunction

    task automatic run_page(input logic [63:0] pgaddr, input int awm, input int wm,
                            input int bm, input int el, input int st_at,
                            input bit do_reset, input bit mid_start,
                            input int exp_writes, input bit exp_done,
                            input bit exp_err, input string tag);
        logic [ADDR_W-1:0] base;
        int  n;
        bit  pulsed;
        aw_mode = awm; w_mode = wm; b_mode = bm; err_line = el;
        stall_at   = st_at;
        stall_left = (st_at >= 0) ? 10 : 0;
        fill_src();
        src_on = 1'b1;
        if (do_reset) begin
            rst = 1'b1;
            tick();
            tick();
            rst = 1'b0;
        end
        clear_mon();
        u.dcmp_wr_pgaddr = pgaddr;
        u.dcmp_wr_start  = 1'b1;
        start_cyc        = cyc;
        tick();
        u.dcmp_wr_start  = 1'b0;
        u.dcmp_wr_pgaddr = 64'hDEAD_BEEF_0000_0000;
        pulsed = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (done_cnt > 0 || u.dcmp_wr_error) break;
            if (mid_start && !pulsed && stall_left > 0 && stall_left <= 5) begin
                u.dcmp_wr_pgaddr = 64'h5000;
                u.dcmp_wr_start  = 1'b1;
                tick();
                u.dcmp_wr_start  = 1'b0;
                pulsed = 1'b1;
            end else begin
                tick();
            end
        end
        repeat (20) tick();

        base = pgaddr & ~64'hFFF;
        check({tag, " aw_count"}, aw_q.size(), exp_writes);
        check({tag, " w_count"}, w_q.size(), exp_writes);
        n = (aw_q.size() < exp_writes) ? aw_q.size() : exp_writes;
        for (int i = 0; i < n; i++)
            check($sformatf("%s awaddr[%0d]", tag, i), aw_q[i], base + ADDR_W'(64 * i));
        n = (w_q.size() < exp_writes) ? w_q.size() : exp_writes;
        for (int i = 0; i < n; i++)
            check($sformatf("%s wdata[%0d]", tag, i), w_q[i], src[i]);
        check({tag, " done_pulses"}, done_cnt, exp_done ? 1 : 0);
        check({tag, " error"}, u.dcmp_wr_error, exp_err);
        check({tag, " busy_after"}, u.busy, exp_err);
        check({tag, " payload_stable"}, stab_err, 0);
        check({tag, " fixed_fields"}, fmt_err, 0);
        check({tag, " one_outstanding"}, overlap_err, 0);
        if (st_at != 0) check({tag, " start_latency"}, first_aw_cyc - start_cyc, 2);
        if (mid_start) check({tag, " busy_start_pulsed"}, pulsed, 1'b1);
    endtask

    initial begin
        logic [63:0] r0, r1;
        int          snap_aw, snap_w;
        bit          reached;
        u.dcmp_wr_start  = 1'b0;
        u.dcmp_wr_pgaddr = '0;
        u.line_valid     = 1'b0;
        u.line_data      = '0;
        u.awready        = 1'b0;
        u.wready         = 1'b0;
        u.bvalid         = 1'b0;
        u.bresp          = 2'b00;

        r0 = {$urandom(), $urandom()};
        r1 = {$urandom(), $urandom()};
        vecs[0] = '{64'h8000_0123,          0,  0, 0, -1, 64, 1'b1, 1'b0};
        vecs[1] = '{64'h1_2345_6FFF,         3,  0, 0, -1, 64, 1'b1, 1'b0};
        vecs[2] = '{64'hAB_CDEF_1000,        0,  3, 0, -1, 64, 1'b1, 1'b0};
        vecs[3] = '{r0,                     -1, -1, 1, -1, 64, 1'b1, 1'b0};
        vecs[4] = '{r1,                     -1, -1, 1, -1, 64, 1'b1, 1'b0};
        vecs[5] = '{64'h4000_0000,           0,  0, 0,  5,  6, 1'b0, 1'b1};

        tick();
        tick();
        @(negedge clk);
        check("reset outputs", outs(), 7'd0);
        tick();

        for (int v = 0; v < 6; v++)
            run_page(vecs[v].pgaddr, vecs[v].awm, vecs[v].wm, vecs[v].bm, vecs[v].el,
                     -1, 1'b1, 1'b0, vecs[v].exp_writes, vecs[v].exp_done,
                     vecs[v].exp_err, $sformatf("vec%0d", v));

        run_page(64'h7000_0000, -1, -1, 0, -1, 20, 1'b1, 1'b1, 64, 1'b1, 1'b0, "stall");

        // Abort mid-page, then a fresh page from 0x1000 without another reset
        aw_mode = 0; w_mode = 0; b_mode = 0; err_line = -1; stall_at = -1; stall_left = 0;
        fill_src();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        clear_mon();
        u.dcmp_wr_pgaddr = 64'h3_0000_0000;
        u.dcmp_wr_start  = 1'b1;
        tick();
        u.dcmp_wr_start  = 1'b0;
        reached = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (aw_q.size() > 30) begin reached = 1'b1; break; end
            tick();
        end
        check("midreset reached line30", reached, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("midreset outputs", outs(), 7'd0);
        snap_aw = aw_q.size();
        snap_w  = w_q.size();
        repeat (10) tick();
        check("midreset no aw after", aw_q.size(), snap_aw);
        check("midreset no w after", w_q.size(), snap_w);
        check("midreset idle", u.busy, 1'b0);

        run_page(64'h1000, 0, 0, 0, -1, -1, 1'b0, 1'b0, 64, 1'b1, 1'b0, "fresh");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
